// File: rtl/pll_reset_gen_if.sv
// Lock-qualification and domain-reset signals between the PLL reset generator and its environment.
interface pll_reset_gen_if;
  logic       locked;
  logic       ext_reset_req;
  logic       rst_out;
  logic       ready;
  logic [7:0] lock_lost_count;
  logic [1:0] state;

  modport master (
    output locked, ext_reset_req,
    input  rst_out, ready, lock_lost_count, state
  );

  modport slave (
    input  locked, ext_reset_req,
    output rst_out, ready, lock_lost_count, state
  );
endinterface

// File: rtl/pll_reset_gen.sv
// Holds the clock_in domain in reset until the PLL lock has been stable for a
// qualification window, then releases it; re-asserts on lock loss or request.
module pll_reset_gen #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RESET_HOLD_CYCLES  = 16
) (
  input  logic             clock_in,
  input  logic             reset,
  pll_reset_gen_if.slave   bus
);

  localparam int unsigned CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                    LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned LOST_W  = 8;

  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [LOST_W-1:0] LOST_SAT    = '1;

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    STABILIZE  = 2'd1,
    HOLD_RESET = 2'd2,
    RUN        = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LOST_W-1:0] lost_q, lost_d;
  logic              rst_q, rst_d;
  logic              ready_q, ready_d;

  // Metastability chain for the asynchronous lock indicator
  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      lost_q  <= '0;
      rst_q   <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  // Lock loss always wins over a reset request; requests outside RUN are dropped
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD_RESET;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD_RESET: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          if (lost_q != LOST_SAT) begin
            lost_d = lost_q + LOST_W'(1);
          end
        end else if (bus.ext_reset_req) begin
          state_d = HOLD_RESET;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    rst_d   = (state_d != RUN);
    ready_d = (state_d == RUN);
  end

  assign bus.rst_out         = rst_q;
  assign bus.ready           = ready_q;
  assign bus.lock_lost_count = lost_q;
  assign bus.state           = state_q;

endmodule

// File: tb/tb_pll_reset_gen.sv
// Directed vector bench for pll_reset_gen with short qualification windows.
module tb_pll_reset_gen;

  logic clock_in;
  logic reset;
  int   checks;
  int   failures;

  pll_reset_gen_if bus ();

  pll_reset_gen #(
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (8),
    .RESET_HOLD_CYCLES  (4)
  ) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .bus      (bus)
  );

  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  typedef struct {
    logic       rst_in;
    logic       locked;
    logic       ext;
    logic       exp_rst;
    logic       exp_ready;
    logic [1:0] exp_state;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic l, input logic e,
                     input logic xr, input logic xy, input logic [1:0] xs,
                     input logic [7:0] xc);
    vec_t v;
    v.rst_in = r; v.locked = l; v.ext = e;
    v.exp_rst = xr; v.exp_ready = xy; v.exp_state = xs; v.exp_cnt = xc;
    vecs.push_back(v);
  endtask

  // Edges E2..E14 of a clean qualification (locked held high since E0)
  task automatic add_qual(input logic [7:0] c);
    for (int i = 0; i < 8; i++) add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, c);
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, c);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, c);
  endtask

  task automatic step(input logic r, input logic l, input logic e);
    reset             = r;
    bus.locked        = l;
    bus.ext_reset_req = e;
    @(posedge clock_in);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int n;
    int exp_lost;
    checks   = 0;
    failures = 0;
    reset             = 1'b1;
    bus.locked        = 1'b0;
    bus.ext_reset_req = 1'b0;

    // Power-up qualification, one-cycle lock loss, ext request, simultaneous request+loss
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
    add_qual(8'd0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 8'd0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 8'd0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 8'd0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd1);
    add_qual(8'd1);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 8'd1);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 8'd1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 8'd1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 8'd1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 8'd1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 8'd1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd2);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd2);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_in, vecs[i].locked, vecs[i].ext);
      chk($sformatf("vec%0d rst_out", i), int'(bus.rst_out), int'(vecs[i].exp_rst));
      chk($sformatf("vec%0d ready", i), int'(bus.ready), int'(vecs[i].exp_ready));
      chk($sformatf("vec%0d state", i), int'(bus.state), int'(vecs[i].exp_state));
      chk($sformatf("vec%0d lost", i), int'(bus.lock_lost_count), int'(vecs[i].exp_cnt));
    end

    // Glitch at the 5th STABILIZE cycle restarts qualification without releasing reset
    step(1'b1, 1'b0, 1'b0);
    chk("glitch reset lost", int'(bus.lock_lost_count), 0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0);
    chk("glitch pre state", int'(bus.state), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("glitch low rst_out", int'(bus.rst_out), 1);
    for (int k = 0; k < 15; k++) begin
      step(1'b0, 1'b1, 1'b0);
      if (k < 14) chk($sformatf("glitch hold k%0d", k), int'(bus.rst_out), 1);
      if (k == 1) chk("glitch back to wait", int'(bus.state), 0);
    end
    chk("glitch release rst_out", int'(bus.rst_out), 0);
    chk("glitch release ready", int'(bus.ready), 1);
    chk("glitch lost unchanged", int'(bus.lock_lost_count), 0);

    // Reset mid-HOLD_RESET, then a clean power-up-like requalification
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0);
    chk("midhold state", int'(bus.state), 2);
    step(1'b1, 1'b1, 1'b1);
    chk("midhold reset rst_out", int'(bus.rst_out), 1);
    chk("midhold reset ready", int'(bus.ready), 0);
    chk("midhold reset state", int'(bus.state), 0);
    chk("midhold reset lost", int'(bus.lock_lost_count), 0);
    for (int k = 0; k < 15; k++) begin
      step(1'b0, 1'b1, 1'b0);
      if (k < 14) chk($sformatf("postreset hold k%0d", k), int'(bus.rst_out), 1);
    end
    chk("postreset release", int'(bus.rst_out), 0);

    // 260 lock losses: counter saturates at 255
    exp_lost = 0;
    for (int i = 0; i < 260; i++) begin
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      if (exp_lost < 255) exp_lost++;
      chk($sformatf("sat lost i%0d", i), int'(bus.lock_lost_count), exp_lost);
      chk($sformatf("sat state i%0d", i), int'(bus.state), 0);
      n = 0;
      while (!bus.ready && n < 40) begin
        step(1'b0, 1'b1, 1'b0);
        n++;
      end
      chk($sformatf("sat requal cycles i%0d", i), n, 14);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    chk("sat hold lost", int'(bus.lock_lost_count), 255);
    chk("sat run state", int'(bus.state), 3);

    // Reset mid-RUN clears the saturated counter
    step(1'b1, 1'b1, 1'b1);
    chk("midrun reset rst_out", int'(bus.rst_out), 1);
    chk("midrun reset ready", int'(bus.ready), 0);
    chk("midrun reset state", int'(bus.state), 0);
    chk("midrun reset lost", int'(bus.lock_lost_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_reset_gen.md
PLL_RESET_GEN -- requirements
Module: pll_reset_gen

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flops synchronising `locked` (legal 2..4).
REQ-002 Parameter LOCK_STABLE_CYCLES, default 1024, consecutive synchronised-locked cycles required before reset release (legal 1..65535).
REQ-003 Parameter RESET_HOLD_CYCLES, default 16, cycles `rst_out` stays high after lock is stable (legal 1..65535).
REQ-004 clock_in  input  1  domain clock (PLL 200 MHz output); all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high block reset.
REQ-006 locked  input  1  PLL lock indicator; asynchronous to clock_in.
REQ-007 ext_reset_req  input  1  synchronous request to re-issue the domain reset while running.
REQ-008 rst_out  output  1  registered active-high reset for the clock_in domain.
REQ-009 ready  output  1  registered; high only in RUN.
REQ-010 lock_lost_count  output  8  saturating count of lock losses seen in RUN.
REQ-011 state  output  2  current FSM state encoding (debug).

Function
REQ-012 `locked` SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (locked_s) drives logic.
REQ-013 FSM states, encoded: WAIT_LOCK=0, STABILIZE=1, HOLD_RESET=2, RUN=3.
REQ-014 WAIT_LOCK: locked_s=1 -> STABILIZE with cycle counter cleared to 0; otherwise stay.
REQ-015 STABILIZE: locked_s=0 -> WAIT_LOCK; counter==LOCK_STABLE_CYCLES-1 -> HOLD_RESET, counter=0; else counter+1 (state occupies exactly LOCK_STABLE_CYCLES cycles).
REQ-016 HOLD_RESET: locked_s=0 -> WAIT_LOCK; counter==RESET_HOLD_CYCLES-1 -> RUN; else counter+1 (exactly RESET_HOLD_CYCLES cycles).
REQ-017 RUN: locked_s=0 -> WAIT_LOCK and lock_lost_count+1; else ext_reset_req=1 -> HOLD_RESET, counter=0; else stay.
REQ-018 Lock loss SHALL take priority over ext_reset_req in the same cycle; ext_reset_req outside RUN is ignored.
REQ-019 rst_out and ready SHALL be registered on the same edge as the state update: rst_out=0 and ready=1 iff next state is RUN.
REQ-020 Release latency: with E0 = first edge sampling locked=1 and locked held high, rst_out falls at edge E0+SYNC_STAGES+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES.
REQ-021 Assert latency: with E0 = first edge sampling locked=0 in RUN, rst_out rises and ready falls at edge E0+SYNC_STAGES.
REQ-022 lock_lost_count SHALL saturate at 255 and never wrap; cleared only by reset.
REQ-023 Counter width SHALL be $clog2 of max(LOCK_STABLE_CYCLES,RESET_HOLD_CYCLES)+1; counter never exceeds parameter-1.
REQ-024 Any locked_s=0 glitch in STABILIZE or HOLD_RESET SHALL restart qualification from WAIT_LOCK, with rst_out held high throughout.

Reset
REQ-025 reset=1 at an edge SHALL force: sync chain all 0, state=WAIT_LOCK, counter=0, rst_out=1, ready=0, lock_lost_count=0, taking precedence over all other inputs, including mid-STABILIZE/HOLD_RESET/RUN.
REQ-026 After reset deasserts, behaviour SHALL be identical to power-up from WAIT_LOCK; rst_out SHALL never be 0 in any state other than RUN.

Verification (SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4)
REQ-027 Reset, then locked rises and stays high -> rst_out=1 through E13, rst_out=0/ready=1 from E14, state=3.
REQ-028 In RUN, locked drops for 1 cycle -> rst_out=1, state=0 at E2, lock_lost_count=1; once locked returns, the full 14-edge requalification repeats.
REQ-029 locked pulses low for 1 cycle at the 5th STABILIZE cycle -> return to WAIT_LOCK, rst_out never drops, lock_lost_count unchanged, release 14 edges after locked re-samples high.
REQ-030 In RUN, ext_reset_req one cycle -> rst_out=1 for exactly 4 cycles, then RUN; simultaneous ext_reset_req and lock loss -> WAIT_LOCK, count+1.
REQ-031 Force 260 lock losses in RUN -> lock_lost_count reads 255 and stays 255.
REQ-032 reset asserted mid-HOLD_RESET and mid-RUN -> next edge all outputs at REQ-025 values; count=0.
